// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready flow control,
// synchronous flush, optional skid entry and a saturating stall counter.
module pipe_stage_reg #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 2,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY,
      FULL,
      SKID_FULL
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [DATA_W-1:0] mainData;
   logic [DATA_W-1:0] skidData;
   logic [CTRL_W-1:0] mainCtrl;
   logic [CTRL_W-1:0] skidCtrl;
   logic              readyReg;
   logic              accept;
   logic              emit;
   logic              loadMain;
   logic              loadSkid;
   logic              fromSkid;
   logic [CNT_W-1:0]  stallCnt;

   assign valid_o     = (state != EMPTY);
   assign ctrl_o      = valid_o ? mainCtrl : '0;
   assign data_o      = mainData;
   assign stall_cnt_o = stallCnt;
   assign emit        = valid_o && ready_i;
   assign accept      = valid_i && ready_o;

   generate
      if (SKID != 0) begin : gSkid
         assign ready_o = readyReg && !rst_i;
      end else begin : gNoSkid
         assign ready_o = (!valid_o || ready_i) && !rst_i;
      end
   endgenerate

   always_comb begin
      stateNext = state;
      loadMain  = 1'b0;
      loadSkid  = 1'b0;
      fromSkid  = 1'b0;
      if (flush_i) begin
         stateNext = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  loadMain  = 1'b1;
                  stateNext = FULL;
               end
            end
            FULL: begin
               if (accept && emit) begin
                  loadMain = 1'b1;
               end else if (accept && (SKID != 0)) begin
                  loadSkid  = 1'b1;
                  stateNext = SKID_FULL;
               end else if (emit) begin
                  stateNext = EMPTY;
               end
            end
            SKID_FULL: begin
               if (emit) begin
                  loadMain  = 1'b1;
                  fromSkid  = 1'b1;
                  stateNext = FULL;
               end
            end
            default: stateNext = EMPTY;
         endcase
      end
   end

   // ready comes up the cycle after reset releases, hence reset value 1
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= EMPTY;
         mainData <= '0;
         mainCtrl <= '0;
         skidData <= '0;
         skidCtrl <= '0;
         readyReg <= 1'b1;
         stallCnt <= '0;
      end else begin
         state    <= stateNext;
         readyReg <= (stateNext != SKID_FULL);
         if (loadMain) begin
            mainData <= fromSkid ? skidData : data_i;
            mainCtrl <= fromSkid ? skidCtrl : ctrl_i;
         end
         if (loadSkid) begin
            skidData <= data_i;
            skidCtrl <= ctrl_i;
         end
         if (valid_o && !ready_i && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
         end
      end
   end

endmodule
